mem_fill_ctrl: RTL and testbench

- Upstream stage of the 1 KiB max/min search datapath.
- Accepts a byte stream over a valid/ready handshake and writes it into the 1024-entry search memory at sequential addresses 0..DEPTH-1.
- After the last write it pulses `start` to the max/min control FSM, then waits for that FSM's `done`.
- Reports completion to the host with a one-cycle `fill_done` pulse.

---
 rtl/mem_fill_ctrl.sv | 108 ++++++++++
 tb/tb_mem_fill_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_ctrl.sv
// mem_fill_ctrl: loads a byte stream into the search memory at sequential
// addresses, kicks the max/min search FSM, and reports completion to the host.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no run in progress; waiting for load_req
// FILL   | accepting bytes and writing them to wr_ptr, one per handshake
// KICK   | last word written; one-cycle start pulse to the search FSM
// WAIT   | waiting for search_done from the search FSM
// FIN    | one-cycle fill_done pulse to the host, then back to IDLE
module mem_fill_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              start,
    input  logic              search_done,
    output logic              busy,
    output logic              fill_done,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_KICK = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic              xfer;
    logic              last_word;

    // in_ready is constant-high in FILL, so a transfer is simply in_valid there
    assign xfer      = (state == S_FILL) && in_valid;
    assign last_word = (wr_ptr == ADDR_W'(DEPTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: state_nxt = load_req ? S_FILL : S_IDLE;
            S_FILL: state_nxt = (xfer && last_word) ? S_KICK : S_FILL;
            S_KICK: state_nxt = S_WAIT;
            S_WAIT: state_nxt = search_done ? S_FIN : S_WAIT;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; address and data are forced to zero outside FILL
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        start     = 1'b0;
        fill_done = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_FILL: begin
                in_ready  = 1'b1;
                mem_we    = in_valid;
                mem_addr  = wr_ptr;
                mem_wdata = in_data;
            end
            S_KICK: start     = 1'b1;
            S_FIN:  fill_done = 1'b1;
            default: ;
        endcase
    end

    // Write pointer and word count; the count survives FIN so the host can read it
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (state == S_IDLE && load_req) begin
            wr_ptr   <= '0;
            wr_count <= '0;
        end else if (xfer) begin
            wr_ptr   <= last_word ? '0 : wr_ptr + 1'b1;
            wr_count <= wr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// tb_mem_fill_ctrl: directed runs against a run-level reference model
// (words written, start issued, done seen) compared every cycle.
module tb_mem_fill_ctrl;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              start;
    logic              search_done;
    logic              busy;
    logic              fill_done;
    logic [ADDR_W:0]   wr_count;

    mem_fill_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
        .search_done(search_done), .busy(busy), .fill_done(fill_done),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Run-level model: a run is active from load_req until one cycle after
    // search_done is seen; words go to consecutive addresses until DEPTH are
    // written, then one start cycle, then the wait for done, then fill_done.
    bit m_valid   = 0;
    bit m_active  = 0;
    int m_n       = 0;
    int m_cnt     = 0;
    bit m_started = 0;
    bit m_seen    = 0;

    // Scoreboard of events seen in the current run
    int n_we, n_start, last_we_cyc, start_cyc, fd_cyc, first_addr;

    // Per-cycle compare against the model, then advance the model past the next edge
    always @(negedge clk) begin
        bit filling, kick, fin;
        filling = m_active && (m_n < DEPTH);
        kick    = m_active && (m_n == DEPTH) && !m_started;
        fin     = m_active && m_seen;
        if (m_valid) begin
            chk("in_ready",  int'(in_ready),  int'(filling));
            chk("mem_we",    int'(mem_we),    int'(filling && in_valid));
            chk("mem_addr",  int'(mem_addr),  filling ? m_n : 0);
            chk("mem_wdata", int'(mem_wdata), filling ? int'(in_data) : 0);
            chk("start",     int'(start),     int'(kick));
            chk("busy",      int'(busy),      int'(m_active));
            chk("fill_done", int'(fill_done), int'(fin));
            chk("wr_count",  int'(wr_count),  m_cnt);
            if (mem_we) begin
                chk("wdata_is_addr", int'(mem_wdata), int'(mem_addr[7:0]));
                n_we++;
                last_we_cyc = cyc;
                if (first_addr < 0) first_addr = int'(mem_addr);
            end
            if (start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (fill_done) fd_cyc = cyc;
        end
        if (rst) begin
            m_valid = 1; m_active = 0; m_n = 0; m_cnt = 0; m_started = 0; m_seen = 0;
        end else if (!m_active) begin
            if (load_req) begin
                m_active = 1; m_n = 0; m_cnt = 0; m_started = 0; m_seen = 0;
            end
        end else if (filling) begin
            if (in_valid) begin
                m_n++;
                m_cnt = m_n;
            end
        end else if (kick) begin
            m_started = 1;
        end else if (fin) begin
            m_active = 0;
        end else if (search_done) begin
            m_seen = 1;
        end
    end

    // Feed DEPTH bytes (value = word index); optional stall every 3rd cycle,
    // optional reset after abort_at words, optional stray load_req/search_done.
    task automatic stream(input bit gaps, input int abort_at, input bit inject,
                          output int words);
        int i = 0;
        int c = 0;
        bit hs;
        while (i < DEPTH && c < 4000) begin
            in_valid    = !(gaps && (c % 3 == 2));
            in_data     = 8'(i);
            load_req    = inject && (c == 150);
            search_done = inject && (c == 150 || c == 400);
            if (abort_at >= 0 && i == abort_at) begin
                rst      = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                words = i;
                return;
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) i++;
            c++;
        end
        in_valid    = 1'b0;
        load_req    = 1'b0;
        search_done = 1'b0;
        words = i;
        if (i < DEPTH) chk("stream_timeout", i, DEPTH);
    endtask

    task automatic run(input bit gaps, input int abort_at, input bit inject,
                       input int wait_cycles);
        int words;
        int sd_cyc;
        bit got = 0;
        n_we = 0; n_start = 0; first_addr = -1;
        last_we_cyc = -100; start_cyc = -200; fd_cyc = -300;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
        stream(gaps, abort_at, inject, words);
        if (abort_at >= 0) begin
            @(negedge clk);
            chk("abort_in_ready", int'(in_ready), 0);
            chk("abort_wr_count", int'(wr_count), 0);
            chk("abort_busy",     int'(busy), 0);
            repeat (10) @(negedge clk);
            chk("abort_writes", n_we, abort_at);
            chk("abort_start",  n_start, 0);
            @(posedge clk); #1;
            return;
        end
        // This is the KICK cycle: a done here must be ignored
        search_done = 1'b1;
        @(posedge clk); #1;
        search_done = 1'b0;
        if (inject) begin
            load_req = 1'b1;
            @(posedge clk); #1;
            load_req = 1'b0;
        end
        repeat (wait_cycles) @(posedge clk);
        #1;
        search_done = 1'b1;
        sd_cyc = cyc;
        @(posedge clk); #1;
        search_done = 1'b0;
        for (int k = 0; k < 5 && !got; k++) begin
            @(negedge clk);
            got = fill_done;
        end
        chk("fill_done_seen", int'(got), 1);
        chk("fin_wr_count",   int'(wr_count), DEPTH);
        @(negedge clk);
        chk("busy_after_fin", int'(busy), 0);
        chk("idle_wr_count",  int'(wr_count), DEPTH);
        chk("n_writes",    n_we, DEPTH);
        chk("n_start",     n_start, 1);
        chk("first_addr",  first_addr, 0);
        chk("start_lat",   start_cyc - last_we_cyc, 1);
        chk("fd_lat",      fd_cyc - sd_cyc, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0; search_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy",     int'(busy), 0);
            chk("idle_in_ready", int'(in_ready), 0);
            chk("idle_mem_we",   int'(mem_we), 0);
            chk("idle_addr",     int'(mem_addr), 0);
            chk("idle_start",    int'(start), 0);
            chk("idle_count",    int'(wr_count), 0);
        end
        @(posedge clk); #1;
        run(1'b0, -1,  1'b0, 5);
        run(1'b1, -1,  1'b0, 50);
        run(1'b0, 500, 1'b0, 0);
        run(1'b1, -1,  1'b1, 10);
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got %0d expected 0", 1);
        $fatal(1, "timeout");
    end

endmodule
